// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind the unsigned multiplier: sums LEN consecutive
// products per frame and presents each frame sum through a valid/ready output register.
module mac_accumulator #(
   parameter int WIDTH = 12,
   parameter int LEN   = 4,
   parameter int GUARD = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [2*WIDTH-1:0]         prod_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       clear,
   output logic [2*WIDTH+GUARD-1:0]   sum_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy
);

   localparam int ACC_W = 2*WIDTH + GUARD;
   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] sum_next;
   logic             accept;
   logic             handoff;
   logic             last;

   // A pending result blocks input unless it leaves this same cycle.
   assign in_ready = !clear && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign handoff  = out_valid && out_ready;
   assign last     = (cnt == CNT_LAST);
   assign busy     = (cnt != '0);

   assign prod_ext = {{GUARD{1'b0}}, prod_in};
   assign sum_next = (cnt == '0) ? prod_ext : acc + prod_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         sum_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (clear) begin
            acc <= '0;
            cnt <= '0;
         end else if (accept) begin
            if (last) begin
               sum_out <= sum_next;
               cnt     <= '0;
            end else begin
               acc <= sum_next;
               cnt <= cnt + CNT_W'(1);
            end
         end

         // A last-product accept wins over a handoff so back-to-back frames stay valid.
         if (accept && last)
            out_valid <= 1'b1;
         else if (handoff)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and randomized-handshake bench for mac_accumulator (WIDTH=12, LEN=4, GUARD=2).
module tb_mac_accumulator;

   localparam int WIDTH = 12;
   localparam int LEN   = 4;
   localparam int GUARD = 2;
   localparam int ACC_W = 2*WIDTH + GUARD;
   localparam int NFRAMES = 50;

   logic               clk;
   logic               rst_n;
   logic [2*WIDTH-1:0] prod_in;
   logic               in_valid;
   logic               in_ready;
   logic               clear;
   logic [ACC_W-1:0]   sum_out;
   logic               out_valid;
   logic               out_ready;
   logic               busy;

   int checks = 0;
   int errors = 0;

   mac_accumulator #(.WIDTH(WIDTH), .LEN(LEN), .GUARD(GUARD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prod_in   (prod_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .clear     (clear),
      .sum_out   (sum_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one product for the coming rising edge (caller ensures in_ready).
   task automatic push(input logic [2*WIDTH-1:0] p);
      @(negedge clk);
      in_valid = 1'b1;
      prod_in  = p;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; prod_in = '0; clear = 1'b0; out_ready = 1'b1;
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", out_valid); end
      checks++; if (sum_out !== '0) begin errors++; $display("FAIL reset_sum got %0d exp 0", sum_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d exp 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic exp_busy [0:3];
      exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (busy !== exp_busy[i]) begin errors++; $display("FAIL basic_busy%0d got %0d exp %0d", i, busy, exp_busy[i]); end
         in_valid = 1'b1;
         prod_in  = 24'(i + 1);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready%0d got %0d exp 1", i, in_ready); end
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %0d exp 0", busy); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0d exp 1", out_valid); end
      checks++; if (sum_out !== 26'd10) begin errors++; $display("FAIL basic_sum got %0d exp 10", sum_out); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %0d exp 0", out_valid); end
   endtask

   task automatic test_max();
      for (int i = 0; i < 4; i++) push(24'd16769025);
      idle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL max_out_valid got %0d exp 1", out_valid); end
      checks++; if (sum_out !== 26'h3FF8004) begin errors++; $display("FAIL max_sum got %0d exp 67076100", sum_out); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push(24'd1); push(24'd2); push(24'd3); push(24'd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         prod_in  = 24'd5;
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %0d exp 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid%0d got %0d exp 1", i, out_valid); end
         checks++; if (sum_out !== 26'd10) begin errors++; $display("FAIL bp_sum_hold%0d got %0d exp 10", i, sum_out); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0d exp 1", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_handoff got %0d exp 0", out_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_first_accepted got %0d exp 1", busy); end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp2_out_valid got %0d exp 1", out_valid); end
      checks++; if (sum_out !== 26'd20) begin errors++; $display("FAIL bp2_sum got %0d exp 20", sum_out); end
      @(negedge clk);
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      push(24'd7); push(24'd7);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_before got %0d exp 1", busy); end
      clear = 1'b1; in_valid = 1'b1; prod_in = 24'd7;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %0d exp 0", in_ready); end
      @(negedge clk);
      clear = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_after got %0d exp 0", busy); end
      prod_in = 24'd1;
      push(24'd1); push(24'd1); push(24'd1);
      idle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_out_valid got %0d exp 1", out_valid); end
      checks++; if (sum_out !== 26'd4) begin errors++; $display("FAIL clr_sum got %0d exp 4", sum_out); end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      push(24'd2); push(24'd2); push(24'd2); push(24'd2);
      idle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pending got %0d exp 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got %0d exp 0", out_valid); end
      checks++; if (sum_out !== '0) begin errors++; $display("FAIL ar_sum got %0d exp 0", sum_out); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      push(24'd9); push(24'd9);
      idle();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy_before got %0d exp 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %0d exp 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      push(24'd3); push(24'd3); push(24'd3); push(24'd3);
      idle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_out_valid2 got %0d exp 1", out_valid); end
      checks++; if (sum_out !== 26'd12) begin errors++; $display("FAIL ar_sum2 got %0d exp 12", sum_out); end
      @(negedge clk);
   endtask

   task automatic test_random_frames();
      logic [2*WIDTH-1:0] p [NFRAMES*LEN];
      logic [ACC_W-1:0]   exp_sum [NFRAMES];
      int  idx = 0;
      int  n = 0;
      int  cyc = 0;
      bit  hold = 1'b0;
      bit  acc_now;
      for (int f = 0; f < NFRAMES; f++) begin
         exp_sum[f] = '0;
         for (int k = 0; k < LEN; k++) begin
            p[f*LEN+k] = 24'($urandom_range(0, 4095) * $urandom_range(0, 4095));
            exp_sum[f] = exp_sum[f] + ACC_W'(p[f*LEN+k]);
         end
      end
      while (n < NFRAMES && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (idx >= NFRAMES*LEN) in_valid = 1'b0;
         else begin
            if (!hold) in_valid = ($urandom_range(0, 3) != 0);
            prod_in = p[idx];
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         acc_now = in_valid && in_ready;
         if (out_valid && out_ready) begin
            checks++;
            if (sum_out !== exp_sum[n]) begin errors++; $display("FAIL rand_frame%0d got %0d exp %0d", n, sum_out, exp_sum[n]); end
            n++;
         end
         if (acc_now) idx++;
         hold = in_valid && !acc_now;
      end
      checks++;
      if (n != NFRAMES) begin errors++; $display("FAIL rand_timeout frames got %0d exp %0d", n, NFRAMES); end
      idle();
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_extra_output got %0d exp 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_clear();
      test_async_reset();
      test_random_frames();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
